// File: rtl/bf_pkg.sv
// Shared BF definitions: opcode values, loader state encoding and the ASCII encoder,
// used by the program loader and the control FSM decoder.
package bf_pkg;

    localparam int unsigned PMAW_DEF = 8;
    localparam int unsigned OPW_DEF  = 4;

    localparam logic [OPW_DEF-1:0] OP_HALT   = OPW_DEF'(0);
    localparam logic [OPW_DEF-1:0] OP_INC_DP = OPW_DEF'(1);
    localparam logic [OPW_DEF-1:0] OP_DEC_DP = OPW_DEF'(2);
    localparam logic [OPW_DEF-1:0] OP_INC_D  = OPW_DEF'(3);
    localparam logic [OPW_DEF-1:0] OP_DEC_D  = OPW_DEF'(4);
    localparam logic [OPW_DEF-1:0] OP_OUT    = OPW_DEF'(5);
    localparam logic [OPW_DEF-1:0] OP_IN     = OPW_DEF'(6);
    localparam logic [OPW_DEF-1:0] OP_JZ     = OPW_DEF'(7);
    localparam logic [OPW_DEF-1:0] OP_JNZ    = OPW_DEF'(8);

    localparam int unsigned STW = 3;
    localparam logic [STW-1:0] ST_LOAD  = STW'(0);
    localparam logic [STW-1:0] ST_WRITE = STW'(1);
    localparam logic [STW-1:0] ST_TERM  = STW'(2);
    localparam logic [STW-1:0] ST_DONE  = STW'(3);
    localparam logic [STW-1:0] ST_ERROR = STW'(4);

    typedef struct packed {
        logic                valid;
        logic [OPW_DEF-1:0]  op;
    } encResult_t;

    // Map one ASCII code to its opcode; anything outside the BF alphabet is invalid.
    function automatic encResult_t encodeChar(input logic [7:0] c);
        encResult_t r;
        r.valid = 1'b1;
        r.op    = OP_HALT;
        case (c)
            8'h3E:   r.op = OP_INC_DP;
            8'h3C:   r.op = OP_DEC_DP;
            8'h2B:   r.op = OP_INC_D;
            8'h2D:   r.op = OP_DEC_D;
            8'h2E:   r.op = OP_OUT;
            8'h2C:   r.op = OP_IN;
            8'h5B:   r.op = OP_JZ;
            8'h5D:   r.op = OP_JNZ;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector:
// one single-cycle pulse per low-to-high transition of asyncIn.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic asyncIn,
    output logic pulse
);

    // [0],[1] synchronize; [2] holds the previous synchronized level
    logic [2:0] syncQ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            syncQ <= 3'b000;
            pulse <= 1'b0;
        end else begin
            syncQ <= {syncQ[1:0], asyncIn};
            pulse <= syncQ[1] & ~syncQ[2];
        end
    end

endmodule

// File: rtl/bf_program_loader.sv
// Encodes switch characters into BF opcodes and writes them to program memory,
// terminated by HALT. Optional bracket checking is enabled with BF_BRACKET_CHECK_EN.
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int unsigned PMAW = PMAW_DEF,
    parameter int unsigned OPW  = OPW_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      char_in,
    input  logic            enter,
    input  logic            finish,
    output logic [PMAW-1:0] pm_addr,
    output logic [OPW-1:0]  pm_data,
    output logic            pm_wren,
    output logic            load_done,
    output logic [PMAW-1:0] prog_len,
    output logic            busy,
    output logic            err_full,
    output logic            err_unbalanced
);

    logic           enterPulse;
    logic           finishPulse;
    logic [STW-1:0] state;
    logic [STW-1:0] stateNxt;
    logic [PMAW-1:0] addrNxt;
    logic [PMAW-1:0] lenNxt;
    logic [OPW-1:0] dataNxt;
    logic           wrenNxt;
    logic           doneNxt;
    logic           busyNxt;
    logic           fullNxt;
    encResult_t     enc;

    sync_edge uEnterSync (
        .clock   (clock),
        .reset   (reset),
        .asyncIn (enter),
        .pulse   (enterPulse)
    );

    sync_edge uFinishSync (
        .clock   (clock),
        .reset   (reset),
        .asyncIn (finish),
        .pulse   (finishPulse)
    );

    assign enc = encodeChar(char_in);

`ifdef BF_BRACKET_CHECK_EN
    logic [PMAW-1:0] depth;
    logic [PMAW-1:0] depthNxt;
    logic            unbal;
    logic            unbalNxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            depth <= '0;
            unbal <= 1'b0;
        end else begin
            depth <= depthNxt;
            unbal <= unbalNxt;
        end
    end

    assign err_unbalanced = unbal;
`else
    assign err_unbalanced = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_LOAD;
            pm_addr   <= '0;
            pm_data   <= '0;
            pm_wren   <= 1'b0;
            load_done <= 1'b0;
            prog_len  <= '0;
            busy      <= 1'b0;
            err_full  <= 1'b0;
        end else begin
            state     <= stateNxt;
            pm_addr   <= addrNxt;
            pm_data   <= dataNxt;
            pm_wren   <= wrenNxt;
            load_done <= doneNxt;
            prog_len  <= lenNxt;
            busy      <= busyNxt;
            err_full  <= fullNxt;
        end
    end

    // Next state and next register values; finish takes priority over enter
    always_comb begin
        stateNxt = state;
        addrNxt  = pm_addr;
        dataNxt  = pm_data;
        wrenNxt  = 1'b0;
        doneNxt  = load_done;
        lenNxt   = prog_len;
        busyNxt  = 1'b0;
        fullNxt  = err_full;
`ifdef BF_BRACKET_CHECK_EN
        depthNxt = depth;
        unbalNxt = unbal;
`endif
        case (state)
            ST_LOAD: begin
                if (finishPulse) begin
                    stateNxt = ST_TERM;
                    addrNxt  = prog_len;
                    dataNxt  = OPW'(OP_HALT);
                    wrenNxt  = 1'b1;
                    busyNxt  = 1'b1;
`ifdef BF_BRACKET_CHECK_EN
                    if (unbal || (depth != '0)) begin
                        stateNxt = ST_ERROR;
                        addrNxt  = '0;
                        busyNxt  = 1'b0;
                        unbalNxt = 1'b1;
                    end
`endif
                end else if (enterPulse && enc.valid) begin
                    if (&prog_len) begin
                        fullNxt = 1'b1;
                    end else begin
                        stateNxt = ST_WRITE;
                        addrNxt  = prog_len;
                        dataNxt  = OPW'(enc.op);
                        wrenNxt  = 1'b1;
                        busyNxt  = 1'b1;
`ifdef BF_BRACKET_CHECK_EN
                        if (enc.op == OP_JZ) begin
                            depthNxt = depth + PMAW'(1);
                        end else if (enc.op == OP_JNZ) begin
                            if (depth == '0) unbalNxt = 1'b1;
                            else             depthNxt = depth - PMAW'(1);
                        end
`endif
                    end
                end
            end
            ST_WRITE: begin
                lenNxt   = prog_len + PMAW'(1);
                stateNxt = ST_LOAD;
            end
            ST_TERM: begin
                doneNxt  = 1'b1;
                stateNxt = ST_DONE;
            end
            ST_DONE: begin
                stateNxt = ST_DONE;
            end
`ifdef BF_BRACKET_CHECK_EN
            ST_ERROR: begin
                stateNxt = ST_ERROR;
            end
`endif
            default: stateNxt = ST_LOAD;
        endcase
    end

endmodule

// File: tb/tb_bf_program_loader.sv
// Self-checking bench for bf_program_loader: table vectors, directed corner
// sequences and random character streams against a queue-based reference model.
module tb_bf_program_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] char_in;
    logic       enter;
    logic       finish;
    logic [7:0] pm_addr;
    logic [3:0] pm_data;
    logic       pm_wren;
    logic       load_done;
    logic [7:0] prog_len;
    logic       busy;
    logic       err_full;
    logic       err_unbalanced;

    bf_program_loader dut (
        .clock          (clock),
        .reset          (reset),
        .char_in        (char_in),
        .enter          (enter),
        .finish         (finish),
        .pm_addr        (pm_addr),
        .pm_data        (pm_data),
        .pm_wren        (pm_wren),
        .load_done      (load_done),
        .prog_len       (prog_len),
        .busy           (busy),
        .err_full       (err_full),
        .err_unbalanced (err_unbalanced)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [11:0] gotQ[$];
    logic [11:0] expQ[$];

    int mLen;
    bit mTerm;
    bit mLoadDone;
    bit mFull;
    bit mUnbal;
    int mDepth;

    always @(negedge clock) begin
        if (reset && pm_wren) gotQ.push_back({pm_addr, pm_data});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic int refOp(input logic [7:0] c);
        string bfChars;
        bfChars = "><+-.,[]";
        for (int i = 0; i < 8; i++)
            if (8'(bfChars[i]) == c) return i + 1;
        return -1;
    endfunction

    task automatic modelClear();
        mLen = 0; mTerm = 0; mLoadDone = 0; mFull = 0; mUnbal = 0; mDepth = 0;
    endtask

    task automatic modelEnter(input logic [7:0] c);
        int op;
        op = refOp(c);
        if (mTerm || op < 0) return;
        if (mLen == 255) begin
            mFull = 1;
            return;
        end
        expQ.push_back({8'(mLen), 4'(op)});
        mLen++;
`ifdef BF_BRACKET_CHECK_EN
        if (op == 7) mDepth++;
        if (op == 8) begin
            if (mDepth == 0) mUnbal = 1;
            else mDepth--;
        end
`endif
    endtask

    task automatic modelFinish();
        if (mTerm) return;
        mTerm = 1;
`ifdef BF_BRACKET_CHECK_EN
        if (mUnbal || mDepth != 0) begin
            mUnbal = 1;
            expQ.push_back(12'h000);
            return;
        end
`endif
        expQ.push_back({8'(mLen), 4'h0});
        mLoadDone = 1;
    endtask

    task automatic press(input logic [7:0] c);
        char_in = c;
        enter = 1'b1;
        tick(5);
        enter = 1'b0;
        tick(5);
        modelEnter(c);
    endtask

    task automatic fin();
        finish = 1'b1;
        tick(5);
        finish = 1'b0;
        tick(5);
        modelFinish();
    endtask

    task automatic pressAndFinish(input logic [7:0] c);
        char_in = c;
        enter = 1'b1;
        finish = 1'b1;
        tick(5);
        enter = 1'b0;
        finish = 1'b0;
        tick(5);
        modelFinish();
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        modelClear();
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic verify(input string tag);
        chk({tag, "_nwr"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            chk({tag, "_wr"}, int'(gotQ[i]), int'(expQ[i]));
        chk({tag, "_len"}, int'(prog_len), mLen);
        chk({tag, "_done"}, int'(load_done), int'(mLoadDone));
        chk({tag, "_full"}, int'(err_full), int'(mFull));
        chk({tag, "_unbal"}, int'(err_unbalanced), int'(mUnbal));
        chk({tag, "_busy"}, int'(busy), 0);
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_addr"}, int'(pm_addr), 0);
        chk({tag, "_data"}, int'(pm_data), 0);
        chk({tag, "_wren"}, int'(pm_wren), 0);
        chk({tag, "_done"}, int'(load_done), 0);
        chk({tag, "_len"}, int'(prog_len), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_full"}, int'(err_full), 0);
        chk({tag, "_unbal"}, int'(err_unbalanced), 0);
    endtask

    typedef struct {
        logic [7:0] c;
        bit         valid;
        logic [3:0] op;
    } vec_t;

    initial begin
        vec_t vecs[12];
        int   addr;
        int   k;
        bit   seen;
        string prog;

        vecs[0]  = '{8'h3E, 1'b1, 4'd1};
        vecs[1]  = '{8'h3C, 1'b1, 4'd2};
        vecs[2]  = '{8'h2B, 1'b1, 4'd3};
        vecs[3]  = '{8'h2D, 1'b1, 4'd4};
        vecs[4]  = '{8'h61, 1'b0, 4'd0};
        vecs[5]  = '{8'h2E, 1'b1, 4'd5};
        vecs[6]  = '{8'h2C, 1'b1, 4'd6};
        vecs[7]  = '{8'h20, 1'b0, 4'd0};
        vecs[8]  = '{8'h5B, 1'b1, 4'd7};
        vecs[9]  = '{8'h5D, 1'b1, 4'd8};
        vecs[10] = '{8'h00, 1'b0, 4'd0};
        vecs[11] = '{8'h3F, 1'b0, 4'd0};

        reset = 1'b0;
        char_in = 8'h00;
        enter = 1'b0;
        finish = 1'b0;
        modelClear();
        tick(3);
        checkAllZero("reset");
        reset = 1'b1;
        tick(2);

        // First-write latency from the first clock edge that samples enter
        char_in = 8'h2B;
        enter = 1'b1;
        k = 0;
        seen = 0;
        while (k < 10 && !seen) begin
            @(posedge clock);
            k++;
            @(negedge clock);
            if (pm_wren) seen = 1;
        end
        chk("latency", k, 4);
        enter = 1'b0;
        tick(5);
        modelEnter(8'h2B);
        verify("lat");

        // Table of single characters with their expected opcodes
        doReset();
        addr = 0;
        foreach (vecs[i]) begin
            press(vecs[i].c);
            chk("vec_nwr", gotQ.size(), vecs[i].valid ? 1 : 0);
            if (vecs[i].valid && gotQ.size() > 0) begin
                chk("vec_addr", int'(gotQ[0][11:4]), addr);
                chk("vec_op", int'(gotQ[0][3:0]), int'(vecs[i].op));
                addr++;
            end
            chk("vec_len", int'(prog_len), addr);
            gotQ.delete();
            expQ.delete();
        end

        // "+[-]." then finish
        doReset();
        prog = "+[-].";
        for (int i = 0; i < prog.len(); i++) press(8'(prog[i]));
        fin();
        chk("prog_len5", int'(prog_len), 5);
        verify("prog");
        press(8'h2B);
        fin();
        verify("after_done");

        // enter and finish together: finish wins
        doReset();
        press(8'h2B);
        pressAndFinish(8'h2D);
        verify("coincide");

        // memory full
        doReset();
        repeat (255) press(8'h2B);
        verify("fill");
        press(8'h2B);
        verify("overflow");
        fin();
        verify("full_fin");

        // async reset mid-load
        doReset();
        press(8'h2B);
        press(8'h5B);
        press(8'h2E);
        verify("preload");
        #2 reset = 1'b0;
        #1 checkAllZero("async_rst");
        tick(2);
        reset = 1'b1;
        tick(2);
        modelClear();
        gotQ.delete();
        expQ.delete();
        press(8'h3E);
        verify("post_rst");

`ifdef BF_BRACKET_CHECK_EN
        doReset();
        press(8'h5D);
        press(8'h2B);
        fin();
        verify("unbal_close");
        doReset();
        press(8'h5B);
        press(8'h5B);
        fin();
        verify("unbal_open");
`endif

        // random character streams
        for (int r = 0; r < 4; r++) begin
            int n;
            doReset();
            n = $urandom_range(10, 40);
            for (int i = 0; i < n; i++) begin
                logic [7:0] c;
                string pool;
                pool = "><+-.,[]";
                if ($urandom_range(0, 9) < 7) c = 8'(pool[$urandom_range(0, 7)]);
                else c = 8'($urandom);
                press(c);
                if (i % 8 == 7) verify("rnd");
            end
            fin();
            verify("rnd_fin");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
